// File: rtl/count_seq_monitor.sv
// count_seq_monitor: receive-side checker for a free-running modulo-2^WIDTH
// counter. It locks onto the +1 sequence, flags breaks while locked, and keeps
// saturating break and wrap statistics.
//
// Handshake: there is no valid/ready pair. `en` is a qualifier only. On an
// edge with en=1 the monitor samples count_in. On an edge with en=0 it holds
// all state, and err reads 0 in the following cycle.
module count_seq_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_LEN   = 2,
    parameter int ERR_CNT_W  = 8,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [WIDTH-1:0]      count_in,
    output logic                  locked,
    output logic                  err,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [WRAP_CNT_W-1:0] wrap_count,
    output logic [WIDTH-1:0]      last_count,
    output logic [1:0]            dbg_state
);

    // run counts 0..LOCK_LEN-1 while acquiring, so LOCK_LEN must fit.
    localparam int RUN_W = $clog2(LOCK_LEN + 1);
    localparam logic [RUN_W-1:0] LOCK_LEN_R = RUN_W'(LOCK_LEN);
    localparam logic [WIDTH-1:0] MAX_VAL    = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        prev_q, prev_d;
    logic [RUN_W-1:0]        run_q, run_d;
    logic                    locked_q, locked_d;
    logic                    err_q, err_d;
    logic [ERR_CNT_W-1:0]    err_count_q, err_count_d;
    logic [WRAP_CNT_W-1:0]   wrap_count_q, wrap_count_d;
    logic [WIDTH-1:0]        last_count_q, last_count_d;

    logic [WIDTH-1:0]        prev_inc;
    logic [RUN_W-1:0]        run_inc;
    logic                    is_match;

    // The increment wraps naturally in WIDTH bits, so MAX is followed by 0.
    assign prev_inc = prev_q + WIDTH'(1);
    assign run_inc  = run_q + RUN_W'(1);
    assign is_match = (count_in == prev_inc);

    // Next-state and next-output logic. A stalled counter (count_in == prev)
    // counts as a mismatch because it is not prev+1.
    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        run_d        = run_q;
        locked_d     = locked_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;
        last_count_d = last_count_q;

        if (en) begin
            last_count_d = count_in;
            case (state_q)
                ST_SYNC: begin
                    if (count_in == '0) begin
                        prev_d  = '0;
                        run_d   = '0;
                        state_d = ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    prev_d = count_in;
                    if (is_match) begin
                        run_d = run_inc;
                        if (run_inc == LOCK_LEN_R) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    prev_d = count_in;
                    if (is_match) begin
                        if (prev_q == MAX_VAL && wrap_count_q != {WRAP_CNT_W{1'b1}}) begin
                            wrap_count_d = wrap_count_q + WRAP_CNT_W'(1);
                        end
                    end else begin
                        // An unexpected 0 lands here too, which catches a counter reset.
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        run_d    = '0;
                        state_d  = ST_ACQ;
                        if (err_count_q != {ERR_CNT_W{1'b1}}) begin
                            err_count_d = err_count_q + ERR_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d  = ST_SYNC;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_SYNC;
            prev_q       <= '0;
            run_q        <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
            last_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            run_q        <= run_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
            last_count_q <= last_count_d;
        end
    end

    assign locked     = locked_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;
    assign last_count = last_count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor. Two instances share one stimulus stream: one
// uses the default widths, and one uses 2-bit error and wrap counters to
// exercise saturation. A behavioural model tracks the sequence in terms of
// "streak of correct increments since acquisition".
module tb_count_seq_monitor;

    localparam int WIDTH    = 4;
    localparam int LOCK_LEN = 2;
    localparam int MODV     = 1 << WIDTH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    logic en;
    logic [WIDTH-1:0] count_in;

    always #5 clk = ~clk;

    logic             a_locked, a_err;
    logic [7:0]       a_err_count, a_wrap_count;
    logic [WIDTH-1:0] a_last_count;
    logic [1:0]       a_dbg_state;

    logic             b_locked, b_err;
    logic [1:0]       b_err_count, b_wrap_count;
    logic [WIDTH-1:0] b_last_count;
    logic [1:0]       b_dbg_state;

    count_seq_monitor #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_CNT_W(8), .WRAP_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in),
        .locked(a_locked), .err(a_err), .err_count(a_err_count),
        .wrap_count(a_wrap_count), .last_count(a_last_count), .dbg_state(a_dbg_state)
    );

    count_seq_monitor #(.WIDTH(WIDTH), .LOCK_LEN(LOCK_LEN), .ERR_CNT_W(2), .WRAP_CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in),
        .locked(b_locked), .err(b_err), .err_count(b_err_count),
        .wrap_count(b_wrap_count), .last_count(b_last_count), .dbg_state(b_dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // have_ref: a 0 has been seen since reset. streak: consecutive +1 samples
    // since the sequence was last (re)started. Locked means streak >= LOCK_LEN.
    bit m_have_ref;
    int m_prev, m_streak, m_errs, m_wraps, m_last;
    bit m_err;

    function automatic bit m_locked();
        return m_have_ref && (m_streak >= LOCK_LEN);
    endfunction

    function automatic int sat(input int v, input int w);
        int top = (1 << w) - 1;
        return (v > top) ? top : v;
    endfunction

    function automatic int m_state();
        if (!m_have_ref) return 0;
        return m_locked() ? 2 : 1;
    endfunction

    task automatic model_reset();
        m_have_ref = 1'b0;
        m_prev = 0; m_streak = 0; m_errs = 0; m_wraps = 0; m_last = 0; m_err = 1'b0;
    endtask

    task automatic model_step(input bit en_v, input int in_v);
        bit was_locked;
        m_err = 1'b0;
        if (!en_v) return;
        m_last = in_v;
        if (!m_have_ref) begin
            if (in_v == 0) begin
                m_have_ref = 1'b1;
                m_prev = 0;
                m_streak = 0;
            end
        end else begin
            was_locked = m_locked();
            if (in_v == (m_prev + 1) % MODV) begin
                if (was_locked && m_prev == MODV - 1) m_wraps++;
                if (m_streak < 1000) m_streak++;
            end else begin
                if (was_locked) begin
                    m_err = 1'b1;
                    m_errs++;
                end
                m_streak = 0;
            end
            m_prev = in_v;
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("locked",     a_locked,     m_locked());
            check("err",        a_err,        m_err);
            check("err_count",  a_err_count,  sat(m_errs, 8));
            check("wrap_count", a_wrap_count, sat(m_wraps, 8));
            check("last_count", a_last_count, m_last);
            check("state",      a_dbg_state,  m_state());
            check("sat_locked", b_locked,     m_locked());
            check("sat_err",    b_err,        m_err);
            check("sat_errcnt", b_err_count,  sat(m_errs, 2));
            check("sat_wrapcnt",b_wrap_count, sat(m_wraps, 2));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        model_reset();
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input bit en_v, input int v);
        en = en_v;
        count_in = WIDTH'(v);
        @(posedge clk);
        model_step(en_v, v);
        #1;
    endtask

    task automatic run_to(input int from_v, input int to_v);
        int v = from_v;
        forever begin
            step(1'b1, v);
            if (v == to_v) break;
            v = (v + 1) % MODV;
        end
    endtask

    // ---------------- stimulus ----------------
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    int v;
    int cnt;

    initial begin
        reset = 1'b1; en = 1'b0; count_in = '0;
        model_reset();

        // 1: reset then 0,1,2,3
        do_reset(2);
        chk_on = 1'b1;
        check("rst_locked", a_locked, 0);
        check("rst_last",   a_last_count, 0);
        step(1'b1, 0);
        step(1'b1, 1);
        check("pre_lock", a_locked, 0);
        step(1'b1, 2);
        check("lock_after_2", a_locked, 1);
        check("last_is_2", a_last_count, 2);
        step(1'b1, 3);

        // 2: two wraps
        run_to(4, 0);
        check("wrap_1", a_wrap_count, 1);
        run_to(1, 0);
        check("wrap_2", a_wrap_count, 2);
        check("no_errs", a_err_count, 0);

        // 3: break 5 -> 7, relock at 9
        run_to(1, 5);
        step(1'b1, 7);
        check("brk_err", a_err, 1);
        check("brk_errcnt", a_err_count, 1);
        check("brk_unlock", a_locked, 0);
        step(1'b1, 8);
        check("brk_err_once", a_err, 0);
        check("relock_pending", a_locked, 0);
        step(1'b1, 9);
        check("relock", a_locked, 1);

        // 4: hold with en=0 at prev=6
        run_to(10, 6);
        repeat (3) begin
            step(1'b0, 4'hA);
            check("hold_last", a_last_count, 6);
            check("hold_locked", a_locked, 1);
            check("hold_err", a_err, 0);
        end
        step(1'b1, 7);
        check("resume_err", a_err, 0);
        check("resume_locked", a_locked, 1);

        // 5: five break-then-relock cycles, 2-bit error counter
        do_reset(1);
        run_to(0, 2);
        v = 2;
        for (int k = 0; k < 5; k++) begin
            v = (v + 2) % MODV;
            step(1'b1, v);
            check("sat_pulse", b_err, 1);
            check("sat_count", b_err_count, sat_exp[k]);
            v = (v + 1) % MODV;
            step(1'b1, v);
            v = (v + 1) % MODV;
            step(1'b1, v);
            check("sat_relock", b_locked, 1);
        end

        // 6: reset while locked, then 3,4,5 stays in SYNC
        do_reset(1);
        check("r6_locked", a_locked, 0);
        check("r6_errcnt", a_err_count, 0);
        check("r6_wrapcnt", a_wrap_count, 0);
        for (int k = 3; k <= 5; k++) begin
            step(1'b1, k);
            check("r6_sync", a_dbg_state, 0);
            check("r6_noerr", a_err, 0);
        end
        run_to(0, 2);
        check("r6_relock", a_locked, 1);

        // Random: mostly-correct counting with glitches, stalls, idles and resets
        cnt = 2;
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            int val;
            if (r < 2) begin
                do_reset(1);
                cnt = $urandom_range(0, MODV - 1);
            end else begin
                int g = $urandom_range(0, 24);
                if (g == 0)      val = $urandom_range(0, MODV - 1);
                else if (g == 1) val = cnt;
                else if (g == 2) val = 0;
                else             val = (cnt + 1) % MODV;
                if (r >= 15) begin
                    step(1'b1, val);
                    cnt = val;
                end else begin
                    step(1'b0, val);
                end
            end
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
Receive-side checker for the free-running counter's count output.
- Samples the count bus each enabled cycle and locks onto the increment-by-one, modulo 2^WIDTH sequence.
- Reports sequence breaks, keeps saturating error and wrap statistics, and exposes the last sampled value.
- Sits beside the counter in the design and in benches, as the consuming end of the count interface.

Parameters:
WIDTH, 4, width of the monitored count bus
LOCK_LEN, 2, consecutive correct increments required to declare lock (≥1)
ERR_CNT_W, 8, width of the saturating error counter
WRAP_CNT_W, 8, width of the saturating wrap counter

Ports:
clk  input  1  rising-edge clock shared with the counter
reset  input  1  synchronous, active-high reset
en  input  1  sample enable; when 0 the monitor holds all state and performs no check
count_in  input  WIDTH  count value under observation
locked  output  1  high while the sequence is tracked correctly
err  output  1  one-cycle pulse on a sequence break while locked
err_count  output  ERR_CNT_W  number of breaks, saturating at all-ones
wrap_count  output  WRAP_CNT_W  number of locked MAX→0 transitions, saturating
last_count  output  WIDTH  most recently sampled count_in

Behaviour:
Clocking and reset
- One clock, clk. Reset is synchronous and active-high, named reset.
- All outputs are registered; each reflects the sample taken at the previous enabled edge (1-cycle latency).
- At reset: state=SYNC; locked=0, err=0, err_count=0, wrap_count=0, last_count=0; internal prev=0, run=0.
- Reset overrides en and all other inputs.
- Reset mid-operation clears everything; lock must be re-acquired from a 0 sample.

Internal state
- prev: last sampled value.
- run: match counter, wide enough to count to LOCK_LEN.
- "match" means count_in == prev+1, computed modulo 2^WIDTH. MAX = 2^WIDTH-1, so prev=MAX expects 0.

FSM, evaluated only on edges where en=1
- SYNC:
  - count_in==0: prev←0, run←0, go to ACQ.
  - Otherwise stay in SYNC. No error is flagged.
- ACQ:
  - Match: run←run+1, prev←count_in. If run+1==LOCK_LEN, go to LOCKED and set locked=1.
  - Mismatch: prev←count_in, run←0, stay in ACQ. No error is flagged.
- LOCKED:
  - Match: prev←count_in. If prev==MAX and count_in==0, increment wrap_count (saturating).
  - Mismatch: err=1 for one cycle, err_count+1 (saturating), locked←0, prev←count_in, run←0, go to ACQ.

Other rules
- last_count←count_in on every enabled edge, in every state.
- en=0: state, prev, run, counters and locked are held; err=0.
- err is high for at most one cycle per break. Further mismatches in ACQ do not pulse err.
- A 0 sample while LOCKED with prev≠MAX is a break. This deliberately catches an unexpected counter reset.
- Saturated counters stay at all-ones. err still pulses while err_count is saturated.
- count_in equal to prev (a stalled counter) is a mismatch.

Test Plan:
1. Reset 2 cycles, then count_in 0,1,2,3,… with en=1 → locked rises in the cycle after 2 is sampled; err never pulses; last_count tracks count_in with 1-cycle lag.
2. Locked, count_in runs …14,15,0,1 → wrap_count=1 after 0 is sampled; a second full wrap gives wrap_count=2; err_count=0.
3. Locked, inject 5→7 → err pulses exactly one cycle, err_count=1, locked=0; then 8,9 → locked re-asserts after 9 is sampled.
4. Locked at prev=6, en=0 for 3 cycles with count_in=0xA, then en=1 with count_in=7 → no err, locked stays 1, last_count=6 throughout the hold.
5. ERR_CNT_W=2: five break-then-relock cycles → err pulses 5 times, err_count reads 1,2,3,3,3.
6. Locked, assert reset for one cycle, then count_in 3,4,5 → locked=0 and all counters 0; remains in SYNC until count_in=0 is seen; no err.
